elevator_display: RTL and testbench

ELEVATOR_DISPLAY -- requirements
Module: elevator_display

---
 rtl/elevator_pkg.sv | 40 ++++
 rtl/elevator_pixel_gen.sv | 69 ++++++
 rtl/elevator_display.sv | 129 ++++++++++++
 tb/tb_elevator_display.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types, geometry constants and helpers for the elevator display.
package elevator_pkg;

  localparam int NUM_FLOORS  = 8;
  localparam int FLOOR_PITCH = 56;
  localparam int STEP        = 2;
  localparam int DOOR_FRAMES = 60;
  localparam int CAR_X0      = 288;
  localparam int CAR_W       = 64;
  localparam int CAR_H       = 48;
  localparam int CAR_BASE    = 428;

  // Screen and decoration geometry derived from the car layout.
  localparam int SCREEN_H    = 480;
  localparam int DOOR_GAP_X0 = 312;
  localparam int DOOR_GAP_W  = 16;
  localparam int MARK_X0     = 16;
  localparam int MARK_W      = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } elevator_state_t;

  // Observable controller state, bundled so checkers can bind to one signal.
  typedef struct packed {
    elevator_state_t state;
    logic [8:0]      car_off;
    logic [2:0]      cur_floor;
    logic [2:0]      target;
  } elevator_dbg_t;

  // Car offset (pixels) at which the car is aligned with floor f.
  function automatic logic [8:0] floor_pos(input logic [2:0] f);
    return 9'(f) * 9'(FLOOR_PITCH);
  endfunction

endpackage

// File: rtl/elevator_pixel_gen.sv
// Registered colour generator: car, shaft walls, floor lines, target marker.
module elevator_pixel_gen
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       de,
  input  logic [9:0] car_top,
  input  logic       door_open,
  input  logic       moving,
  input  logic [2:0] target,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B
);

  logic [10:0] car_bot;
  logic [9:0]  band_lo;
  logic [9:0]  band_hi;
  logic        in_car;
  logic        door_gap;
  logic        wall;
  logic        marker;
  logic        on_line;
  logic [11:0] rgb_d;
  logic [11:0] rgb_q;

  assign car_bot  = {1'b0, car_top} + 11'(CAR_H);
  assign in_car   = (x >= 10'(CAR_X0)) && (x < 10'(CAR_X0 + CAR_W)) &&
                    (y >= car_top) && ({1'b0, y} < car_bot);
  assign door_gap = (x >= 10'(DOOR_GAP_X0)) && (x < 10'(DOOR_GAP_X0 + DOOR_GAP_W));
  assign wall     = (x == 10'(CAR_X0 - 2)) || (x == 10'(CAR_X0 + CAR_W + 1));
  // The target band spans one floor pitch ending at the floor's line below it.
  assign band_lo  = 10'(SCREEN_H - FLOOR_PITCH) - {1'b0, floor_pos(target)};
  assign band_hi  = band_lo + 10'(FLOOR_PITCH);
  assign marker   = (x >= 10'(MARK_X0)) && (x < 10'(MARK_X0 + MARK_W)) &&
                    (y >= band_lo) && (y < band_hi);

  // Floor lines sit one pitch apart, counting up from the bottom edge.
  always_comb begin
    on_line = 1'b0;
    for (int k = 1; k <= NUM_FLOORS; k++) begin
      if (y == 10'(SCREEN_H - FLOOR_PITCH * k)) on_line = 1'b1;
    end
  end

  // Priority colour selection, blanked outside the visible area.
  always_comb begin
    rgb_d = 12'h000;
    if (!de)                rgb_d = 12'h000;
    else if (in_car)        rgb_d = (door_open && door_gap) ? 12'h000 : 12'hFFF;
    else if (wall)          rgb_d = 12'h00F;
    else if (on_line)       rgb_d = 12'h888;
    else if (moving && marker) rgb_d = 12'hF00;
  end

  // One-cycle pipeline register toward the VGA controller.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rgb_q <= 12'h000;
    else       rgb_q <= rgb_d;
  end

  assign R = rgb_q[11:8];
  assign G = rgb_q[7:4];
  assign B = rgb_q[3:0];

endmodule

// File: rtl/elevator_display.sv
// Elevator controller: request handshake, car motion per frame, door timer.
// Handshake: a request is taken on a rising clk edge where target_valid=1 and
// ready=1; ready is high only while IDLE, and requests seen otherwise are dropped.
module elevator_display
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       de,
  input  logic       frame_start,
  input  logic [2:0] target_floor,
  input  logic       target_valid,
  output logic       ready,
  output logic [2:0] cur_floor,
  output logic       moving,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B
);

  elevator_state_t state_q, state_d;
  logic [8:0]      car_off_q, car_off_d;
  logic [8:0]      step_up, step_dn;
  logic [2:0]      cur_floor_q, cur_floor_d;
  logic [2:0]      target_q, target_d;
  logic [5:0]      door_cnt_q, door_cnt_d;
  logic [9:0]      car_top;
  elevator_dbg_t   dbg;

  assign step_up = car_off_q + 9'(STEP);
  assign step_dn = car_off_q - 9'(STEP);

  // Next-state logic: accept in IDLE, step on frame_start, time the door.
  always_comb begin
    state_d     = state_q;
    car_off_d   = car_off_q;
    cur_floor_d = cur_floor_q;
    target_d    = target_q;
    door_cnt_d  = door_cnt_q;
    case (state_q)
      IDLE: begin
        if (target_valid) begin
          target_d   = target_floor;
          door_cnt_d = 6'd0;
          if (target_floor > cur_floor_q)      state_d = MOVE_UP;
          else if (target_floor < cur_floor_q) state_d = MOVE_DOWN;
          else                                 state_d = DOOR_OPEN;
        end
      end
      MOVE_UP: begin
        if (frame_start) begin
          car_off_d = step_up;
          if (step_up == floor_pos(target_q)) begin
            state_d     = DOOR_OPEN;
            cur_floor_d = target_q;
            door_cnt_d  = 6'd0;
          end else if (step_up == floor_pos(cur_floor_q + 3'd1)) begin
            cur_floor_d = cur_floor_q + 3'd1;
          end
        end
      end
      MOVE_DOWN: begin
        if (frame_start) begin
          car_off_d = step_dn;
          if (step_dn == floor_pos(target_q)) begin
            state_d     = DOOR_OPEN;
            cur_floor_d = target_q;
            door_cnt_d  = 6'd0;
          end else if (step_dn == floor_pos(cur_floor_q - 3'd1)) begin
            cur_floor_d = cur_floor_q - 3'd1;
          end
        end
      end
      DOOR_OPEN: begin
        if (frame_start) begin
          if (door_cnt_q == 6'(DOOR_FRAMES - 1)) begin
            state_d    = IDLE;
            door_cnt_d = 6'd0;
          end else begin
            door_cnt_d = door_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      car_off_q   <= 9'd0;
      cur_floor_q <= 3'd0;
      target_q    <= 3'd0;
      door_cnt_q  <= 6'd0;
    end else begin
      state_q     <= state_d;
      car_off_q   <= car_off_d;
      cur_floor_q <= cur_floor_d;
      target_q    <= target_d;
      door_cnt_q  <= door_cnt_d;
    end
  end

  assign dbg = '{state: state_q, car_off: car_off_q, cur_floor: cur_floor_q, target: target_q};

  assign ready     = (dbg.state == IDLE);
  assign moving    = (dbg.state == MOVE_UP) || (dbg.state == MOVE_DOWN);
  assign cur_floor = dbg.cur_floor;
  assign car_top   = 10'(CAR_BASE) - {1'b0, dbg.car_off};

  elevator_pixel_gen u_pixel_gen (
    .clk       (clk),
    .nrst      (nrst),
    .x         (x),
    .y         (y),
    .de        (de),
    .car_top   (car_top),
    .door_open (dbg.state == DOOR_OPEN),
    .moving    (moving),
    .target    (dbg.target),
    .R         (R),
    .G         (G),
    .B         (B)
  );

endmodule

// File: tb/tb_elevator_display.sv
// Bench for elevator_display: directed scenarios plus randomized trips
// checked against a floor/position/door-timer model and a pixel model.
module tb_elevator_display;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       de = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] target_floor = '0;
  logic       target_valid = 1'b0;
  logic       ready;
  logic [2:0] cur_floor;
  logic       moving;
  logic [3:0] R, G, B;
  logic [11:0] rgb;

  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  assign rgb = {R, G, B};

  elevator_display dut (
    .clk(clk), .nrst(nrst), .x(x), .y(y), .de(de), .frame_start(frame_start),
    .target_floor(target_floor), .target_valid(target_valid), .ready(ready),
    .cur_floor(cur_floor), .moving(moving), .R(R), .G(G), .B(B)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pixel model: screen layout rules in plain arithmetic.
  function automatic logic [11:0] ref_pixel(int px, int py, bit pde, int coff,
                                            bit door, bit mov, int tgt);
    int ctop;
    ctop = 428 - coff;
    if (!pde) return 12'h000;
    if (px >= 288 && px < 352 && py >= ctop && py < ctop + 48) begin
      if (door && px >= 312 && px < 328) return 12'h000;
      return 12'hFFF;
    end
    if (px == 286 || px == 353) return 12'h00F;
    if (py >= 32 && py <= 424 && (480 - py) % 56 == 0) return 12'h888;
    if (mov && px >= 16 && px < 48 && py >= 424 - 56 * tgt && py < 480 - 56 * tgt)
      return 12'hF00;
    return 12'h000;
  endfunction

  // Driver tasks
  task automatic frame_pulse();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame_pulse();
  endtask

  task automatic request(input int f);
    @(negedge clk);
    target_floor = 3'(f);
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) nrst = 1'b0;
    @(negedge clk) nrst = 1'b1;
  endtask

  task automatic set_pixel(input int px, input int py, input bit pde);
    @(negedge clk);
    x = 10'(px); y = 10'(py); de = pde;
    @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    x = 10'd300; y = 10'd450; de = 1'b1; target_valid = 1'b1; target_floor = 3'd4;
    repeat (3) @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving got %b want 0", moving); end
    n_checks++; if (cur_floor !== 3'd0) begin n_fail++; $display("FAIL reset_floor got %0d want 0", cur_floor); end
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", rgb); end
    n_checks++; if (dut.dbg.car_off !== 9'd0) begin n_fail++; $display("FAIL reset_car_off got %0d want 0", dut.dbg.car_off); end
    target_valid = 1'b0; de = 1'b0;
    @(negedge clk) nrst = 1'b1;
  endtask

  task automatic test_trip_floor3();
    request(3);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL trip3_ready_drop got %b want 0", ready); end
    n_checks++; if (dut.dbg.state !== MOVE_UP) begin n_fail++; $display("FAIL trip3_state got %0d want MOVE_UP", dut.dbg.state); end
    frames(28);
    n_checks++; if (cur_floor !== 3'd1) begin n_fail++; $display("FAIL trip3_pass1 got %0d want 1", cur_floor); end
    frames(55);
    n_checks++; if (dut.dbg.car_off !== 9'd166) begin n_fail++; $display("FAIL trip3_off83 got %0d want 166", dut.dbg.car_off); end
    n_checks++; if (dut.dbg.state !== MOVE_UP) begin n_fail++; $display("FAIL trip3_still_up got %0d want MOVE_UP", dut.dbg.state); end
    frame_pulse();
    n_checks++; if (dut.dbg.car_off !== 9'd168) begin n_fail++; $display("FAIL trip3_off84 got %0d want 168", dut.dbg.car_off); end
    n_checks++; if (cur_floor !== 3'd3) begin n_fail++; $display("FAIL trip3_floor got %0d want 3", cur_floor); end
    n_checks++; if (dut.dbg.state !== DOOR_OPEN) begin n_fail++; $display("FAIL trip3_door got %0d want DOOR_OPEN", dut.dbg.state); end
    frames(59);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL trip3_door59 got %b want 0", ready); end
    frame_pulse();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL trip3_door60 got %b want 1", ready); end
  endtask

  task automatic test_same_floor();
    do_reset();
    request(0);
    n_checks++; if (dut.dbg.state !== DOOR_OPEN) begin n_fail++; $display("FAIL same_state got %0d want DOOR_OPEN", dut.dbg.state); end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL same_moving got %b want 0", moving); end
    frames(59);
    n_checks++; if (dut.dbg.car_off !== 9'd0) begin n_fail++; $display("FAIL same_off got %0d want 0", dut.dbg.car_off); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL same_door59 got %b want 0", ready); end
    frame_pulse();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL same_door60 got %b want 1", ready); end
  endtask

  task automatic test_pixels();
    set_pixel(300, 450, 1'b1);
    n_checks++; if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL pix_car got %h want FFF", rgb); end
    set_pixel(300, 450, 1'b0);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL pix_blank got %h want 000", rgb); end
    set_pixel(286, 100, 1'b1);
    n_checks++; if (rgb !== 12'h00F) begin n_fail++; $display("FAIL pix_wall got %h want 00F", rgb); end
    request(0);
    set_pixel(320, 450, 1'b1);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL pix_door_gap got %h want 000", rgb); end
    set_pixel(300, 450, 1'b1);
    n_checks++; if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL pix_door_side got %h want FFF", rgb); end
    frames(60);
  endtask

  task automatic test_ignore_while_moving();
    do_reset();
    request(5);
    frames(10);
    request(2);
    n_checks++; if (dut.dbg.state !== MOVE_UP) begin n_fail++; $display("FAIL ign_state got %0d want MOVE_UP", dut.dbg.state); end
    frames(101);
    n_checks++; if (cur_floor !== 3'd3) begin n_fail++; $display("FAIL ign_pass got %0d want 3", cur_floor); end
    frames(169);
    n_checks++; if (cur_floor !== 3'd5) begin n_fail++; $display("FAIL ign_floor got %0d want 5", cur_floor); end
    n_checks++; if (dut.dbg.car_off !== 9'd280) begin n_fail++; $display("FAIL ign_off got %0d want 280", dut.dbg.car_off); end
    frames(60);
  endtask

  task automatic test_async_reset();
    do_reset();
    request(7);
    frames(50);
    n_checks++; if (dut.dbg.car_off !== 9'd100) begin n_fail++; $display("FAIL ar_off got %0d want 100", dut.dbg.car_off); end
    set_pixel(300, 350, 1'b1);
    n_checks++; if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL ar_pre_rgb got %h want FFF", rgb); end
    @(negedge clk);
    #1 nrst = 1'b0;
    #1;
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL ar_rgb got %h want 000", rgb); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got %b want 1", ready); end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL ar_moving got %b want 0", moving); end
    n_checks++; if (dut.dbg.car_off !== 9'd0) begin n_fail++; $display("FAIL ar_off0 got %0d want 0", dut.dbg.car_off); end
    @(negedge clk) nrst = 1'b1;
    de = 1'b0;
  endtask

  task automatic test_lines_marker();
    set_pixel(10, 424, 1'b1);
    n_checks++; if (rgb !== 12'h888) begin n_fail++; $display("FAIL line424 got %h want 888", rgb); end
    set_pixel(500, 32, 1'b1);
    n_checks++; if (rgb !== 12'h888) begin n_fail++; $display("FAIL line32 got %h want 888", rgb); end
    // Request coinciding with frame_start: state changes, car does not move yet.
    @(negedge clk);
    target_floor = 3'd1; target_valid = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    target_valid = 1'b0; frame_start = 1'b0;
    n_checks++; if (dut.dbg.car_off !== 9'd0) begin n_fail++; $display("FAIL coinc_off got %0d want 0", dut.dbg.car_off); end
    n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL coinc_moving got %b want 1", moving); end
    set_pixel(20, 400, 1'b1);
    n_checks++; if (rgb !== 12'hF00) begin n_fail++; $display("FAIL marker got %h want F00", rgb); end
    set_pixel(20, 430, 1'b1);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL marker_out got %h want 000", rgb); end
    frames(27);
    n_checks++; if (dut.dbg.state !== MOVE_UP) begin n_fail++; $display("FAIL coinc_27 got %0d want MOVE_UP", dut.dbg.state); end
    frame_pulse();
    n_checks++; if (cur_floor !== 3'd1 || dut.dbg.state !== DOOR_OPEN) begin
      n_fail++; $display("FAIL coinc_arrive got floor %0d state %0d want 1 DOOR_OPEN", cur_floor, dut.dbg.state);
    end
    frames(60);
  endtask

  task automatic test_random_trips();
    int pos, cur, tgt, door_left, mode, px, py, b;
    bit pde;
    logic [11:0] e;
    do_reset();
    pos = 0; cur = 0; tgt = 0; door_left = 0; mode = 0;
    for (int trip = 0; trip < 6; trip++) begin
      b = $urandom_range(0, 7);
      request(b);
      tgt = b;
      if (b == cur) begin mode = 2; door_left = 60; end
      else mode = 1;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rnd_accept trip %0d got %b want 0", trip, ready); end
      for (int it = 0; it < 400 && mode != 0; it++) begin
        frame_pulse();
        if (mode == 1) begin
          pos = pos + ((tgt * 56 > pos) ? 2 : -2);
          if (pos % 56 == 0) cur = pos / 56;
          if (pos == tgt * 56) begin mode = 2; door_left = 60; end
        end else if (mode == 2) begin
          door_left--;
          if (door_left == 0) mode = 0;
        end
        n_checks++;
        if (dut.dbg.car_off !== 9'(pos) || cur_floor !== 3'(cur) ||
            ready !== (mode == 0) || moving !== (mode == 1)) begin
          n_fail++;
          $display("FAIL rnd_frame off %0d floor %0d rdy %b mov %b want %0d %0d %b %b",
                   dut.dbg.car_off, cur_floor, ready, moving, pos, cur, mode == 0, mode == 1);
        end
        px = $urandom_range(0, 639);
        if ($urandom_range(0, 1) == 1) begin
          py = 428 - pos - 8 + $urandom_range(0, 63);
          if (py > 479) py = 479;
        end else begin
          py = $urandom_range(0, 479);
        end
        pde = ($urandom_range(0, 7) != 0);
        exp_q.push_back(ref_pixel(px, py, pde, pos, mode == 2, mode == 1, tgt));
        @(negedge clk);
        x = 10'(px); y = 10'(py); de = pde;
        if (mode != 0) begin
          target_valid = 1'b1;
          target_floor = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        target_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (rgb !== e) begin
          n_fail++;
          $display("FAIL rnd_pixel x %0d y %0d de %b got %h want %h", px, py, pde, rgb, e);
        end
      end
      n_checks++; if (mode != 0) begin n_fail++; $display("FAIL rnd_timeout trip %0d mode %0d want 0", trip, mode); end
    end
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_trip_floor3();
    test_same_floor();
    test_pixels();
    test_ignore_while_moving();
    test_async_reset();
    test_lines_marker();
    test_random_trips();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
